// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Lets the instruction-fetch stage and the load/store stage share one
//   single-port unified memory. One access is in flight at a time; the data
//   port has strict priority over a simultaneous fetch.
//
// Handshake semantics (both CPU ports):
//   x_req_i is a level held by the stage until x_ack_o pulses for one cycle
//   (or, for fetch only, until if_flush_i abandons it). A request is taken
//   only in IDLE, and never in the cycle its own ack is high, so a held
//   request is not re-issued. On the memory side, mem_req_o is held high with
//   constant addr/we/wdata until mem_rvalid_i is seen for one cycle. That
//   response completes both reads and writes.
//
// Ports:
//   clk_i, rst_i                  clock, async active-high reset
//   if_req_i/if_addr_i/if_flush_i fetch request, address, redirect cancel
//   if_ack_o/if_rdata_o           fetch completion pulse and instruction
//   dm_req_i/dm_we_i/dm_addr_i/dm_wdata_i  load/store request
//   dm_ack_o/dm_rdata_o           load/store completion pulse and load data
//   mem_req_o/mem_we_o/mem_addr_o/mem_wdata_o  memory request (registered)
//   mem_rvalid_i/mem_rdata_i      memory response
//   stall_o                       combinational pipeline stall
//   err_o                         sticky watchdog error
//   dbg_state_o                   current FSM state (debug observation)
module mem_port_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    input  logic              if_flush_i,
    output logic              if_ack_o,
    output logic [DATA_W-1:0] if_rdata_o,
    input  logic              dm_req_i,
    input  logic              dm_we_i,
    input  logic [ADDR_W-1:0] dm_addr_i,
    input  logic [DATA_W-1:0] dm_wdata_i,
    output logic              dm_ack_o,
    output logic [DATA_W-1:0] dm_rdata_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic              mem_rvalid_i,
    input  logic [DATA_W-1:0] mem_rdata_i,
    output logic              stall_o,
    output logic              err_o,
    output logic [1:0]        dbg_state_o
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_BUSY_IF = 2'd1,
        S_BUSY_DM = 2'd2
    } state_e;

    localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

    state_e              state_q, state_d;
    logic                mem_req_q, mem_req_d;
    logic                mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
    logic                if_ack_q, if_ack_d;
    logic                dm_ack_q, dm_ack_d;
    logic [DATA_W-1:0]   if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0]   dm_rdata_q, dm_rdata_d;
    logic                drop_q, drop_d;
    logic [7:0]          cnt_q, cnt_d;
    logic                err_q, err_d;

    logic                dm_elig, if_elig;
    logic [7:0]          cnt_inc;
    logic                dropped;
    logic [DATA_W-1:0]   rdata_sel;

    // The acked port's own request is masked in its ack cycle.
    assign dm_elig = dm_req_i & ~dm_ack_q;
    assign if_elig = if_req_i & ~if_ack_q & ~if_flush_i;
    assign cnt_inc = cnt_q + 8'd1;

    always_comb begin
        state_d     = state_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if_ack_d    = 1'b0;
        dm_ack_d    = 1'b0;
        if_rdata_d  = if_rdata_q;
        dm_rdata_d  = dm_rdata_q;
        drop_d      = drop_q;
        cnt_d       = cnt_q;
        err_d       = err_q;
        dropped     = 1'b0;
        rdata_sel   = '0;

        case (state_q)
            S_IDLE: begin
                drop_d = 1'b0;
                cnt_d  = 8'd0;
                if (dm_elig) begin
                    state_d     = S_BUSY_DM;
                    mem_req_d   = 1'b1;
                    mem_we_d    = dm_we_i;
                    mem_addr_d  = dm_addr_i;
                    mem_wdata_d = dm_wdata_i;
                end else if (if_elig) begin
                    state_d     = S_BUSY_IF;
                    mem_req_d   = 1'b1;
                    mem_we_d    = 1'b0;
                    mem_addr_d  = if_addr_i;
                    mem_wdata_d = '0;
                end
            end
            S_BUSY_IF, S_BUSY_DM: begin
                cnt_d = cnt_inc;
                // A flush in the completing cycle still suppresses the ack.
                dropped = (state_q == S_BUSY_IF) & (drop_q | if_flush_i);
                if (dropped) begin
                    drop_d = 1'b1;
                end
                // Watchdog fires when this is the TIMEOUT-th busy cycle
                // without a response; a response in that cycle wins.
                if (mem_rvalid_i || (cnt_inc == TIMEOUT_C)) begin
                    rdata_sel = mem_rvalid_i ? mem_rdata_i : '0;
                    err_d     = err_q | ~mem_rvalid_i;
                    state_d   = S_IDLE;
                    mem_req_d = 1'b0;
                    drop_d    = 1'b0;
                    cnt_d     = 8'd0;
                    if (state_q == S_BUSY_DM) begin
                        dm_ack_d = 1'b1;
                        if (!mem_we_q) begin
                            dm_rdata_d = rdata_sel;
                        end
                    end else if (!dropped) begin
                        if_ack_d   = 1'b1;
                        if_rdata_d = rdata_sel;
                    end
                end
            end
            default: begin
                state_d   = S_IDLE;
                mem_req_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= S_IDLE;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_ack_q    <= 1'b0;
            dm_ack_q    <= 1'b0;
            if_rdata_q  <= '0;
            dm_rdata_q  <= '0;
            drop_q      <= 1'b0;
            cnt_q       <= 8'd0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            if_ack_q    <= if_ack_d;
            dm_ack_q    <= dm_ack_d;
            if_rdata_q  <= if_rdata_d;
            dm_rdata_q  <= dm_rdata_d;
            drop_q      <= drop_d;
            cnt_q       <= cnt_d;
            err_q       <= err_d;
        end
    end

    assign if_ack_o    = if_ack_q;
    assign dm_ack_o    = dm_ack_q;
    assign if_rdata_o  = if_rdata_q;
    assign dm_rdata_o  = dm_rdata_q;
    assign mem_req_o   = mem_req_q;
    assign mem_we_o    = mem_we_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_wdata_o = mem_wdata_q;
    assign err_o       = err_q;
    assign dbg_state_o = state_q;
    assign stall_o     = (if_req_i & ~if_ack_q & ~if_flush_i) | (dm_req_i & ~dm_ack_q);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter (TIMEOUT = 4).
// Inputs change 1 time unit after the rising edge; stall_o is checked just
// before the model advances, registered outputs 1 unit after each edge.
module tb_mem_port_arbiter;

    localparam int TMO = 4;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        if_req_i = 1'b0;
    logic [31:0] if_addr_i = '0;
    logic        if_flush_i = 1'b0;
    logic        if_ack_o;
    logic [31:0] if_rdata_o;
    logic        dm_req_i = 1'b0;
    logic        dm_we_i = 1'b0;
    logic [31:0] dm_addr_i = '0;
    logic [31:0] dm_wdata_i = '0;
    logic        dm_ack_o;
    logic [31:0] dm_rdata_o;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic        mem_rvalid_i = 1'b0;
    logic [31:0] mem_rdata_i = '0;
    logic        stall_o;
    logic        err_o;
    logic [1:0]  dbg_state_o;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: who owns the memory (0 none, 1 fetch, 2 data),
    // busy cycles already spent, and the values the outputs should show.
    int          m_owner, m_busy, lat;
    logic        m_drop, m_we, m_if_ack, m_dm_ack, m_err;
    logic [31:0] m_addr, m_wdata, m_if_rdata, m_dm_rdata;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TMO)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_flush_i(if_flush_i),
        .if_ack_o(if_ack_o), .if_rdata_o(if_rdata_o),
        .dm_req_i(dm_req_i), .dm_we_i(dm_we_i), .dm_addr_i(dm_addr_i),
        .dm_wdata_i(dm_wdata_i), .dm_ack_o(dm_ack_o), .dm_rdata_o(dm_rdata_o),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o), .mem_rvalid_i(mem_rvalid_i),
        .mem_rdata_i(mem_rdata_i), .stall_o(stall_o), .err_o(err_o),
        .dbg_state_o(dbg_state_o)
    );

    // Clock / reset block
    always #5 clk_i = ~clk_i;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_owner = 0; m_busy = 0; lat = 0; m_drop = 0; m_we = 0;
        m_if_ack = 0; m_dm_ack = 0; m_err = 0;
        m_addr = '0; m_wdata = '0; m_if_rdata = '0; m_dm_rdata = '0;
    endtask

    // Advance the model by one clock using the inputs applied this cycle.
    task automatic model_step();
        logic        nia, nda, done, tmo;
        logic [31:0] data;
        nia = 0; nda = 0; done = 0; tmo = 0;
        if (m_owner == 0) begin
            m_busy = 0; m_drop = 0;
            lat = $urandom_range(0, 5);
            if (dm_req_i && !m_dm_ack) begin
                m_owner = 2; m_we = dm_we_i; m_addr = dm_addr_i; m_wdata = dm_wdata_i;
            end else if (if_req_i && !m_if_ack && !if_flush_i) begin
                m_owner = 1; m_we = 0; m_addr = if_addr_i; m_wdata = '0;
            end
        end else begin
            if (m_owner == 1 && if_flush_i) m_drop = 1;
            if (mem_rvalid_i) done = 1;
            else if (m_busy + 1 == TMO) begin done = 1; tmo = 1; m_err = 1; end
            else m_busy = m_busy + 1;
            if (done) begin
                data = tmo ? 32'h0 : mem_rdata_i;
                if (m_owner == 2) begin
                    nda = 1;
                    if (!m_we) m_dm_rdata = data;
                end else if (!m_drop) begin
                    nia = 1;
                    m_if_rdata = data;
                end
                m_owner = 0;
            end
        end
        m_if_ack = nia;
        m_dm_ack = nda;
    endtask

    task automatic check_outputs();
        check_eq("if_ack", if_ack_o, m_if_ack);
        check_eq("dm_ack", dm_ack_o, m_dm_ack);
        check_eq("if_rdata", if_rdata_o, m_if_rdata);
        check_eq("dm_rdata", dm_rdata_o, m_dm_rdata);
        check_eq("mem_req", mem_req_o, m_owner != 0);
        check_eq("mem_we", mem_we_o, m_we);
        check_eq("mem_addr", mem_addr_o, m_addr);
        check_eq("mem_wdata", mem_wdata_o, m_wdata);
        check_eq("err", err_o, m_err);
    endtask

    // Driver: inputs already applied; check stall, advance one clock.
    task automatic tick();
        #1;
        check_eq("stall", stall_o,
                 (if_req_i & ~m_if_ack & ~if_flush_i) | (dm_req_i & ~m_dm_ack));
        model_step();
        @(posedge clk_i);
        #1;
        check_outputs();
    endtask

    task automatic idle_inputs();
        if_req_i = 0; if_flush_i = 0; dm_req_i = 0; dm_we_i = 0; mem_rvalid_i = 0;
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_outs"},
                 {if_ack_o, dm_ack_o, mem_req_o, mem_we_o, err_o} != 0 ||
                 if_rdata_o != 0 || dm_rdata_o != 0 || mem_addr_o != 0 || mem_wdata_o != 0,
                 32'd0);
    endtask

    task automatic random_inputs();
        logic prev_flush;
        prev_flush = if_flush_i;
        if (!(if_req_i && !m_if_ack && !prev_flush)) begin
            if_req_i  = ($urandom_range(0, 2) != 0);
            if_addr_i = $urandom & 32'hFFFF_FFFC;
        end
        if_flush_i = ($urandom_range(0, 7) == 0);
        if (!(dm_req_i && !m_dm_ack)) begin
            dm_req_i   = ($urandom_range(0, 2) == 0);
            dm_we_i    = $urandom_range(0, 1);
            dm_addr_i  = $urandom;
            dm_wdata_i = $urandom;
        end
        if (m_owner != 0) mem_rvalid_i = (m_busy == lat);
        else              mem_rvalid_i = ($urandom_range(0, 9) == 0);
        mem_rdata_i = $urandom;
    endtask

    initial begin
        model_reset();
        // Reset state
        #12;
        check_all_zero("reset");
        check_eq("reset_stall", stall_o, 1'b0);
        rst_i = 0;

        // Single fetch, zero-wait memory
        if_req_i = 1; if_addr_i = 32'h40;
        tick();
        check_eq("tp1_mem_req", mem_req_o, 1'b1);
        check_eq("tp1_mem_addr", mem_addr_o, 32'h40);
        check_eq("tp1_mem_we", mem_we_o, 1'b0);
        mem_rvalid_i = 1; mem_rdata_i = 32'h8C22_0004;
        tick();
        check_eq("tp1_if_ack", if_ack_o, 1'b1);
        check_eq("tp1_if_rdata", if_rdata_o, 32'h8C22_0004);
        mem_rvalid_i = 0;
        tick();
        if_req_i = 0;
        tick();

        // Simultaneous requests: store wins, fetch served in dm ack cycle
        if_req_i = 1; if_addr_i = 32'h44;
        dm_req_i = 1; dm_we_i = 1; dm_addr_i = 32'h10; dm_wdata_i = 32'hDEAD_BEEF;
        tick();
        check_eq("tp2_mem_we", mem_we_o, 1'b1);
        check_eq("tp2_mem_wdata", mem_wdata_o, 32'hDEAD_BEEF);
        mem_rvalid_i = 1; mem_rdata_i = 32'h1111_2222;
        tick();
        check_eq("tp2_dm_ack", dm_ack_o, 1'b1);
        dm_req_i = 0; mem_rvalid_i = 0;
        tick();
        check_eq("tp2_if_addr", mem_addr_o, 32'h44);
        mem_rvalid_i = 1; mem_rdata_i = 32'h0BAD_F00D;
        tick();
        check_eq("tp2_if_ack", if_ack_o, 1'b1);
        idle_inputs();
        tick();

        // Wait states: load answered in the 4th busy cycle (== TIMEOUT)
        dm_req_i = 1; dm_we_i = 0; dm_addr_i = 32'h20;
        tick();
        repeat (3) begin
            tick();
            check_eq("tp3_req_hold", mem_req_o, 1'b1);
            check_eq("tp3_addr_hold", mem_addr_o, 32'h20);
        end
        mem_rvalid_i = 1; mem_rdata_i = 32'h1234_5678;
        tick();
        check_eq("tp3_dm_rdata", dm_rdata_o, 32'h1234_5678);
        check_eq("tp3_no_err", err_o, 1'b0);
        idle_inputs();
        tick();

        // Flush during BUSY_IF, then a fresh fetch at 0x80
        if_req_i = 1; if_addr_i = 32'h60;
        tick();
        if_flush_i = 1;
        tick();
        if_flush_i = 0; if_addr_i = 32'h80;
        mem_rvalid_i = 1; mem_rdata_i = 32'hAAAA_5555;
        tick();
        check_eq("tp4_no_ack", if_ack_o, 1'b0);
        check_eq("tp4_rdata_kept", if_rdata_o, 32'h0BAD_F00D);
        mem_rvalid_i = 0;
        tick();
        check_eq("tp4_new_addr", mem_addr_o, 32'h80);
        mem_rvalid_i = 1; mem_rdata_i = 32'h0102_0304;
        tick();
        check_eq("tp4_if_ack", if_ack_o, 1'b1);
        check_eq("tp4_if_rdata", if_rdata_o, 32'h0102_0304);
        idle_inputs();
        tick();

        // Watchdog on a load that never answers
        dm_req_i = 1; dm_we_i = 0; dm_addr_i = 32'h30;
        tick();
        repeat (TMO) tick();
        check_eq("tp5_req_drop", mem_req_o, 1'b0);
        check_eq("tp5_dm_ack", dm_ack_o, 1'b1);
        check_eq("tp5_rdata0", dm_rdata_o, 32'h0);
        check_eq("tp5_err", err_o, 1'b1);
        dm_req_i = 0; mem_rvalid_i = 1; mem_rdata_i = 32'hFFFF_FFFF;
        tick();
        check_eq("tp5_late_ignored", dm_ack_o, 1'b0);
        check_eq("tp5_err_sticky", err_o, 1'b1);
        idle_inputs();
        tick();

        // Async reset in the middle of BUSY_DM
        dm_req_i = 1; dm_we_i = 1; dm_addr_i = 32'h34; dm_wdata_i = 32'h5A5A_5A5A;
        tick();
        #3 rst_i = 1;
        #1;
        check_all_zero("tp6_async");
        model_reset();
        #2 rst_i = 0;
        tick();
        check_eq("tp6_reaccept", mem_addr_o, 32'h34);
        mem_rvalid_i = 1;
        tick();
        check_eq("tp6_dm_ack", dm_ack_o, 1'b1);
        idle_inputs();
        tick();

        // Randomized traffic
        for (int i = 0; i < 800; i++) begin
            random_inputs();
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
